// File: rtl/rv_fetch.sv
// rv_fetch: instruction fetch stage. Owns the fetch PC, issues single-outstanding
// Wishbone-classic reads, buffers {pc, instr} pairs in a small prefetch FIFO and
// flushes the prefetched stream when execute redirects via jump_valid/jump_ready.
module rv_fetch #(
  parameter logic [29:0] RESET_PC   = 30'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        ibus_cyc_o,
  output logic        ibus_stb_o,
  output logic [29:0] ibus_adr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_dat_i,
  input  logic        jump_valid_i,
  input  logic [29:0] jump_dst_i,
  output logic        jump_ready_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [29:0] pc_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t        r_state;
  logic [29:0]   r_fpc;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;

  // Prefetch storage; no reset needed, r_cnt qualifies every entry.
  logic [29:0]   r_pc_mem    [FIFO_DEPTH];
  logic [31:0]   r_instr_mem [FIFO_DEPTH];

  logic          w_cyc;
  logic          w_ack;
  logic          w_jump_acc;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_cnt_next;
  logic          w_space;

  // Bus strobes come straight from the registered FSM state.
  assign w_cyc        = (r_state == ST_REQ);
  assign ibus_cyc_o   = w_cyc;
  assign ibus_stb_o   = w_cyc;
  assign ibus_adr_o   = r_fpc;

  // A redirect is only taken between bus cycles, so a read is never aborted.
  assign jump_ready_o = ~w_cyc | ibus_ack_i;
  assign w_jump_acc   = jump_valid_i & jump_ready_o;

  // Ack is meaningful only inside a cycle; a word acked alongside a redirect is wrong-path.
  assign w_ack        = w_cyc & ibus_ack_i;
  assign w_push       = w_ack & ~w_jump_acc;

  // Head is hidden while a redirect is pending: it belongs to the old path.
  assign valid_o      = (r_cnt != '0) & ~jump_valid_i;
  assign w_pop        = valid_o & ready_i;

  assign instr_o      = r_instr_mem[r_rptr];
  assign pc_o         = r_pc_mem[r_rptr];

  // Occupancy after this cycle's push/pop/flush; a new read needs one free slot beyond it.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_jump_acc) begin
      w_cnt_next = '0;
    end else begin
      w_cnt_next = r_cnt + CW'(w_push) - CW'(w_pop);
    end
    w_space = (w_cnt_next < DEPTH_C);
  end

  // Bus FSM, fetch PC and FIFO occupancy/pointers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_fpc   <= RESET_PC;
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (w_jump_acc) begin
      r_state <= ST_IDLE;
      r_fpc   <= jump_dst_i;
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (w_space) begin
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_ack) begin
            // 30-bit increment wraps 3FFF_FFFF to 0 naturally.
            r_fpc   <= r_fpc + 30'd1;
            r_state <= w_space ? ST_REQ : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // FIFO write port: store {pc, instr} at the tail on each accepted ack.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc_mem[r_wptr]    <= r_fpc;
      r_instr_mem[r_wptr] <= ibus_dat_i;
    end
  end

endmodule
